muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_iter.sv | 157 +++++++++++++++
 tb/tb_muldiv_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_pkg.sv
// rtl/muldiv_iter_pkg.sv - shared muldiv instruction codes, FSM encoding and decode helpers
package muldiv_iter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] INST_NOP    = 8'h00;
  localparam logic [7:0] INST_ADD    = 8'h01;
  localparam logic [7:0] INST_MUL    = 8'h40;
  localparam logic [7:0] INST_MULH   = 8'h41;
  localparam logic [7:0] INST_MULHSU = 8'h42;
  localparam logic [7:0] INST_MULHU  = 8'h43;
  localparam logic [7:0] INST_DIV    = 8'h44;
  localparam logic [7:0] INST_DIVU   = 8'h45;
  localparam logic [7:0] INST_REM    = 8'h46;
  localparam logic [7:0] INST_REMU   = 8'h47;

  function automatic logic is_muldiv(input logic [7:0] inst);
    return inst inside {INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
                        INST_DIV, INST_DIVU, INST_REM, INST_REMU};
  endfunction

  function automatic logic is_div_op(input logic [7:0] inst);
    return inst inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [7:0] inst);
    return inst inside {INST_REM, INST_REMU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add or restoring-subtract step on a 64-bit work register
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] work_in,
  input  logic [31:0] operand,
  output logic [63:0] work_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Divide keeps remainder in [63:32] and dividend/quotient in [31:0]; multiply keeps
  // the accumulator high and the multiplier low, shifting right each step.
  always_comb begin
    sum      = {1'b0, work_in[63:32]} + (work_in[0] ? {1'b0, operand} : 33'd0);
    shifted  = {work_in[63:32], work_in[31]};
    diff     = shifted - {1'b0, operand};
    work_out = {sum, work_in[31:1]};
    if (is_div) begin
      if (!diff[32]) begin
        work_out = {diff[31:0], work_in[30:0], 1'b1};
      end else begin
        work_out = {shifted[31:0], work_in[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative multiply/divide responder for the execute stage
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  inst_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        exception_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
    $error("muldiv_iter: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t      state, state_next;
  logic        md_hit;
  logic [7:0]  op_q;
  logic [31:0] opnd_q;
  logic [63:0] work_q;
  logic        neg_a_q, neg_b_q;
  logic [5:0]  count_q;
  logic [31:0] data_q;
  logic        exc_q;

  logic        in_div, in_rem, sign_a, sign_b, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, fast;
  logic [31:0] fast_data;

  always_comb begin
    md_hit    = is_muldiv(inst_i);
    in_div    = is_div_op(inst_i);
    in_rem    = is_rem_op(inst_i);
    sign_a    = inst_i inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
    sign_b    = inst_i inside {INST_MULH, INST_DIV, INST_REM};
    neg_a     = sign_a & reg1_data_i[31];
    neg_b     = sign_b & reg2_data_i[31];
    mag_a     = neg_a ? -reg1_data_i : reg1_data_i;
    mag_b     = neg_b ? -reg2_data_i : reg2_data_i;
    div_zero  = in_div & (reg2_data_i == 32'd0);
    div_ovf   = (inst_i == INST_DIV || inst_i == INST_REM) &&
                (reg1_data_i == 32'h8000_0000) && (reg2_data_i == 32'hFFFF_FFFF);
    fast      = md_hit & (div_zero | div_ovf);
    if (div_zero) begin
      fast_data = in_rem ? reg1_data_i : 32'hFFFF_FFFF;
    end else begin
      fast_data = in_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  logic [63:0] chain [BITS_PER_CYCLE+1];
  logic [63:0] work_next;

  assign chain[0] = work_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step u_step (
      .is_div   (is_div_op(op_q)),
      .work_in  (chain[g]),
      .operand  (opnd_q),
      .work_out (chain[g+1])
    );
  end

  assign work_next = chain[BITS_PER_CYCLE];

  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, result;

  // Operand sign flags are only set for signed ops, so unsigned ops never get negated.
  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? -work_next : work_next;
    quo_s  = (neg_a_q ^ neg_b_q) ? -work_next[31:0] : work_next[31:0];
    rem_s  = neg_a_q ? -work_next[63:32] : work_next[63:32];
    if (is_div_op(op_q)) begin
      result = is_rem_op(op_q) ? rem_s : quo_s;
    end else begin
      result = (op_q == INST_MUL) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (md_hit) state_next = fast ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (!md_hit) begin
          state_next = S_IDLE;
        end else if (count_q == 6'd1) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = !rst_i && ((state == S_DONE) || (state == S_IDLE && !md_hit));
    exception_o = !rst_i && (state == S_DONE) && exc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= INST_NOP;
      opnd_q  <= 32'd0;
      work_q  <= 64'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      count_q <= 6'd0;
      data_q  <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_hit) begin
            op_q    <= inst_i;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= in_div ? mag_b : mag_a;
            work_q  <= {32'd0, (in_div ? mag_a : mag_b)};
            count_q <= 6'(STEPS);
            exc_q   <= fast & div_zero;
            if (fast) data_q <= fast_data;
          end
        end
        S_BUSY: begin
          if (md_hit) begin
            work_q  <= work_next;
            count_q <= count_q - 6'd1;
            if (count_q == 6'd1) data_q <= result;
          end
        end
        default: exc_q <= 1'b0;
      endcase
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter at BITS_PER_CYCLE 1 and 4
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inst = INST_NOP;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [31:0] data1, data4;
  logic        ready1, ready4, exc1, exc4;

  int checks = 0;
  int failures = 0;
  logic [31:0] last1 = 32'd0;

  muldiv_iter dut1 (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .reg1_data_i(rs1), .reg2_data_i(rs2),
    .data_o(data1), .ready_o(ready1), .exception_o(exc1)
  );

  muldiv_iter #(.BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .reg1_data_i(rs1), .reg2_data_i(rs2),
    .data_o(data4), .ready_o(ready4), .exception_o(exc4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic signed [31:0] sq;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      INST_MUL:    begin p = ua * ub; return p[31:0]; end
      INST_MULH:   begin p = sa * sb; return p[63:32]; end
      INST_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      INST_MULHU:  begin p = ua * ub; return p[63:32]; end
      INST_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      INST_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sq = $signed(a) % $signed(b);
        return sq;
      end
      INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INST_REMU: return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input int bpc, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic divop, signed_div;
    divop      = (op == INST_DIV) || (op == INST_DIVU) || (op == INST_REM) || (op == INST_REMU);
    signed_div = (op == INST_DIV) || (op == INST_REM);
    if (divop && b == 0) return 1;
    if (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32 / bpc + 1;
  endfunction

  // Starts at cycle 0, waits for the selected DUT's ready, then spends one NOP cycle.
  task automatic run_op(input bit sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input string tag);
    int cyc;
    logic rdy;
    inst = op;
    rs1  = a;
    rs2  = b;
    cyc  = 0;
    while (cyc <= 80) begin
      @(negedge clk);
      rdy = sel ? ready4 : ready1;
      if (rdy) break;
      next_cycle();
      cyc++;
      if (cyc == 3) begin
        rs1 = $urandom;
        rs2 = $urandom;
      end
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".data"}, sel ? data4 : data1, exp_d);
    chk({tag, ".exc"}, 32'(sel ? exc4 : exc1), 32'(exp_e));
    if (!sel) last1 = exp_d;
    next_cycle();
    inst = INST_NOP;
    @(negedge clk);
    chk({tag, ".exc_after"}, 32'(sel ? exc4 : exc1), 32'd0);
    chk({tag, ".idle_ready"}, 32'(sel ? ready4 : ready1), 32'd1);
    next_cycle();
  endtask

  initial begin
    logic [7:0] ops [8];
    int pulses [$];
    int p0, p1;
    logic [7:0] op;
    logic [31:0] a, b;
    logic sel;

    ops = '{INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, INST_DIV, INST_DIVU, INST_REM, INST_REMU};

    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset.data", data1, 32'd0);
    chk("reset.ready", 32'(ready1), 32'd0);
    chk("reset.exc", 32'(exc1), 32'd0);
    chk("reset.ready4", 32'(ready4), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", 32'(ready1), 32'd1);
    next_cycle();

    run_op(0, INST_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, "mul_7x6");
    run_op(0, INST_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, "mulh_m1");
    run_op(0, INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "mulhu_max");
    run_op(0, INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu_m1");
    run_op(0, INST_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div_m7_2");
    run_op(0, INST_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem_m7_2");
    run_op(0, INST_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33, "divu_100_7");
    run_op(0, INST_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33, "remu_100_7");
    run_op(0, INST_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "divu_by0");
    run_op(0, INST_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1, "remu_by0");
    run_op(0, INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, "div_ovf");
    run_op(0, INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, "rem_ovf");

    // Flush: DIV dropped to ADD at cycle 10 must be idle at cycle 11.
    inst = INST_DIV;
    rs1  = 32'hFFFF_FFF9;
    rs2  = 32'd2;
    repeat (10) next_cycle();
    inst = INST_ADD;
    @(negedge clk);
    chk("flush.busy_ready", 32'(ready1), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("flush.idle_ready", 32'(ready1), 32'd1);
    chk("flush.data_held", data1, last1);
    next_cycle();
    run_op(0, INST_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 33, "after_flush");

    // Reset in the middle of a MUL.
    inst = INST_MUL;
    rs1  = 32'd3;
    rs2  = 32'd5;
    repeat (15) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.ready_now", 32'(ready1), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("midrst.data", data1, 32'd0);
    chk("midrst.ready", 32'(ready1), 32'd0);
    chk("midrst.exc", 32'(exc1), 32'd0);
    next_cycle();
    rst  = 1'b0;
    inst = INST_NOP;
    @(negedge clk);
    chk("midrst.idle_ready", 32'(ready1), 32'd1);
    next_cycle();
    run_op(0, INST_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33, "after_rst");

    run_op(1, INST_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 1'b0, 9, "bpc4_mul");

    // Back-to-back identical MULs on the 4-bit-per-cycle build.
    inst = INST_MUL;
    rs1  = 32'h1234_5678;
    rs2  = 32'h9ABC_DEF0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ready4) begin
        pulses.push_back(c);
        chk("b2b.data", data4, 32'h242D_2080);
      end
      next_cycle();
    end
    inst = INST_NOP;
    next_cycle();
    p0 = (pulses.size() > 0) ? pulses[0] : 999;
    p1 = (pulses.size() > 1) ? pulses[1] : 999;
    chk("b2b.count", 32'(pulses.size()), 32'd2);
    chk("b2b.first", 32'(p0), 32'd9);
    chk("b2b.second", 32'(p1), 32'd19);

    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 7)];
      sel = (i % 2) == 1;
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3:       begin a = -$urandom_range(0, 1000); b = -$urandom_range(1, 50); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(sel, op, a, b, model(op, a, b),
             ((op == INST_DIV) || (op == INST_DIVU) || (op == INST_REM) || (op == INST_REMU)) && (b == 0),
             model_lat(sel ? 4 : 1, op, a, b), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
